// File: rtl/llc_input_sched_pkg.sv
// Shared LLC types: source ids for the input scheduler.
// Bit positions of the grant vectors follow the llc_src_t encoding.
package llc_input_sched_pkg;

    typedef enum logic [2:0] {
        LLC_RSP        = 3'd0,
        LLC_RST_TB     = 3'd1,
        LLC_REQ        = 3'd2,
        LLC_DMA        = 3'd3,
        LLC_RES_RST    = 3'd4,
        LLC_RES_FLUSH  = 3'd5,
        LLC_RES_DMA_RD = 3'd6,
        LLC_RES_DMA_WR = 3'd7
    } llc_src_t;

    localparam int unsigned LLC_NSRC       = 8;
    localparam int unsigned LLC_STARVE_LIM = 4;

    function automatic llc_src_t llc_src_enc(input logic [LLC_NSRC-1:0] oh);
        llc_src_t s;
        s = LLC_RSP;
        for (int i = 0; i < LLC_NSRC; i++) begin
            if (oh[i]) s = llc_src_t'(i[2:0]);
        end
        return s;
    endfunction

endpackage

// File: rtl/llc_input_sched_if.sv
// Source handshakes, reg-file flags/strobes and decoder slot
// of the LLC input scheduler.
interface llc_input_sched_if;
    import llc_input_sched_pkg::*;

    logic     rsp_valid;
    logic     rst_tb_valid;
    logic     req_valid;
    logic     dma_valid;
    logic     rsp_ready;
    logic     rst_tb_ready;
    logic     req_ready;
    logic     dma_ready;

    logic     rst_stall;
    logic     flush_stall;
    logic     req_stall;
    logic     recall_pending;
    logic     req_pending;
    logic     dma_read_pending;
    logic     dma_write_pending;

    logic     rst_to_resume_in_pipeline;
    logic     flush_to_resume_in_pipeline;
    logic     dma_read_to_resume_in_pipeline;
    logic     dma_write_to_resume_in_pipeline;
    logic     set_rst_to_resume_in_pipeline;
    logic     set_flush_to_resume_in_pipeline;
    logic     set_dma_read_to_resume_in_pipeline;
    logic     set_dma_write_to_resume_in_pipeline;

    logic     out_valid;
    llc_src_t out_sel;
    logic     out_ready;

    modport master (
        input  rsp_valid, rst_tb_valid, req_valid, dma_valid,
        output rsp_ready, rst_tb_ready, req_ready, dma_ready,
        input  rst_stall, flush_stall, req_stall,
        input  recall_pending, req_pending,
        input  dma_read_pending, dma_write_pending,
        input  rst_to_resume_in_pipeline,
        input  flush_to_resume_in_pipeline,
        input  dma_read_to_resume_in_pipeline,
        input  dma_write_to_resume_in_pipeline,
        output set_rst_to_resume_in_pipeline,
        output set_flush_to_resume_in_pipeline,
        output set_dma_read_to_resume_in_pipeline,
        output set_dma_write_to_resume_in_pipeline,
        output out_valid, out_sel,
        input  out_ready
    );

    modport slave (
        output rsp_valid, rst_tb_valid, req_valid, dma_valid,
        input  rsp_ready, rst_tb_ready, req_ready, dma_ready,
        output rst_stall, flush_stall, req_stall,
        output recall_pending, req_pending,
        output dma_read_pending, dma_write_pending,
        output rst_to_resume_in_pipeline,
        output flush_to_resume_in_pipeline,
        output dma_read_to_resume_in_pipeline,
        output dma_write_to_resume_in_pipeline,
        input  set_rst_to_resume_in_pipeline,
        input  set_flush_to_resume_in_pipeline,
        input  set_dma_read_to_resume_in_pipeline,
        input  set_dma_write_to_resume_in_pipeline,
        input  out_valid, out_sel,
        output out_ready
    );

endinterface

// File: rtl/llc_sched_prio.sv
// Fixed-priority one-hot pick over the source eligibility vector.
// dma_over lets DMA beat REQ once the starvation limit is reached.
module llc_sched_prio
    import llc_input_sched_pkg::*;
(
    input  logic [LLC_NSRC-1:0] elig,
    input  logic                dma_over,
    output logic [LLC_NSRC-1:0] grant
);

    logic req_wins;

    assign req_wins = elig[LLC_REQ] && !(dma_over && elig[LLC_DMA]);

    always_comb begin
        grant = '0;
        priority case (1'b1)
            elig[LLC_RSP]:        grant[LLC_RSP]        = 1'b1;
            elig[LLC_RES_RST]:    grant[LLC_RES_RST]    = 1'b1;
            elig[LLC_RES_FLUSH]:  grant[LLC_RES_FLUSH]  = 1'b1;
            elig[LLC_RST_TB]:     grant[LLC_RST_TB]     = 1'b1;
            elig[LLC_RES_DMA_RD]: grant[LLC_RES_DMA_RD] = 1'b1;
            elig[LLC_RES_DMA_WR]: grant[LLC_RES_DMA_WR] = 1'b1;
            req_wins:             grant[LLC_REQ]        = 1'b1;
            elig[LLC_DMA]:        grant[LLC_DMA]        = 1'b1;
            default:              grant = '0;
        endcase
    end

endmodule

// File: rtl/llc_input_sched.sv
// LLC input scheduler: picks one source per cycle into a registered
// slot toward the decoder, with resume strobes and DMA anti-starvation.
module llc_input_sched
    import llc_input_sched_pkg::*;
#(
    parameter int unsigned STARVE_LIM = LLC_STARVE_LIM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rst_state,
    llc_input_sched_if.master io
);

    localparam int CW = $clog2(STARVE_LIM + 1);

    logic                out_valid_q;
    llc_src_t            out_sel_q;
    logic                hold_off;
    logic [CW-1:0]       starve_cnt;
    logic [LLC_NSRC-1:0] elig_raw;
    logic [LLC_NSRC-1:0] elig;
    logic [LLC_NSRC-1:0] pick;
    logic [LLC_NSRC-1:0] gnt;
    logic                block;
    logic                load_en;
    logic                dma_over;
    logic                no_stall;

    assign no_stall = !io.rst_stall && !io.flush_stall;

    always_comb begin
        elig_raw = '0;
        elig_raw[LLC_RSP] = io.rsp_valid;
        elig_raw[LLC_RES_RST] = io.rst_stall
            && !io.rst_to_resume_in_pipeline;
        elig_raw[LLC_RES_FLUSH] = io.flush_stall
            && !io.flush_to_resume_in_pipeline
            && !io.rst_stall;
        elig_raw[LLC_RST_TB] = io.rst_tb_valid
            && no_stall && !io.req_pending;
        elig_raw[LLC_RES_DMA_RD] = io.dma_read_pending
            && !io.dma_read_to_resume_in_pipeline
            && !io.recall_pending;
        elig_raw[LLC_RES_DMA_WR] = io.dma_write_pending
            && !io.dma_write_to_resume_in_pipeline
            && !io.recall_pending;
        elig_raw[LLC_REQ] = io.req_valid && !io.req_stall
            && !io.recall_pending && no_stall;
        elig_raw[LLC_DMA] = io.dma_valid
            && !io.dma_read_pending && !io.dma_write_pending
            && !io.recall_pending && no_stall;
    end

    // Reg-file flags lag a non-RSP pick by a cycle; only RSP may pass meanwhile.
    assign block = hold_off || (out_valid_q && out_sel_q != LLC_RSP);
    assign elig = block ? (elig_raw & LLC_NSRC'(1)) : elig_raw;
    assign dma_over = (starve_cnt == CW'(STARVE_LIM));
    assign load_en = (!out_valid_q || io.out_ready) && !rst_state;

    llc_sched_prio u_prio (
        .elig     (elig),
        .dma_over (dma_over),
        .grant    (pick)
    );

    assign gnt = pick & {LLC_NSRC{load_en}};

    assign io.rsp_ready    = gnt[LLC_RSP];
    assign io.rst_tb_ready = gnt[LLC_RST_TB];
    assign io.req_ready    = gnt[LLC_REQ];
    assign io.dma_ready    = gnt[LLC_DMA];
    assign io.set_rst_to_resume_in_pipeline       = gnt[LLC_RES_RST];
    assign io.set_flush_to_resume_in_pipeline     = gnt[LLC_RES_FLUSH];
    assign io.set_dma_read_to_resume_in_pipeline  = gnt[LLC_RES_DMA_RD];
    assign io.set_dma_write_to_resume_in_pipeline = gnt[LLC_RES_DMA_WR];

    assign io.out_valid = out_valid_q;
    assign io.out_sel   = out_sel_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= 1'b0;
            out_sel_q   <= LLC_RSP;
            hold_off    <= 1'b0;
            starve_cnt  <= '0;
        end else if (rst_state) begin
            out_valid_q <= 1'b0;
            out_sel_q   <= LLC_RSP;
            hold_off    <= 1'b0;
            starve_cnt  <= '0;
        end else begin
            if (load_en) begin
                out_valid_q <= |gnt;
                if (|gnt) out_sel_q <= llc_src_enc(gnt);
            end
            hold_off <= (|gnt) && !gnt[LLC_RSP];
            if (!elig_raw[LLC_DMA] || gnt[LLC_DMA]) begin
                starve_cnt <= '0;
            end else if (gnt[LLC_REQ] && !dma_over) begin
                starve_cnt <= starve_cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_llc_input_sched.sv
// Directed scoreboard bench for llc_input_sched.
module tb_llc_input_sched;

    logic clk;
    logic rst;
    logic rst_state;
    int   total;
    int   bad;
    logic [2:0] q[$];

    llc_input_sched_if io();

    llc_input_sched #(.STARVE_LIM(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .rst_state (rst_state),
        .io        (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse vector bit i corresponds to source id i.
    function automatic logic [2:0] oh2id(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) if (v[i]) r = i[2:0];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic tick(input string tag, input logic [7:0] exp);
        logic [7:0] obs;
        logic [2:0] e;
        @(negedge clk);
        obs = {io.set_dma_write_to_resume_in_pipeline,
               io.set_dma_read_to_resume_in_pipeline,
               io.set_flush_to_resume_in_pipeline,
               io.set_rst_to_resume_in_pipeline,
               io.dma_ready, io.req_ready,
               io.rst_tb_ready, io.rsp_ready};
        if (io.out_valid && io.out_ready) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $error("FAIL %s slot: out_sel=%0d but none expected",
                       tag, io.out_sel);
            end else begin
                e = q.pop_front();
                assert (io.out_sel === e) else begin
                    bad++;
                    $error("FAIL %s slot: out_sel=%0d want %0d",
                           tag, io.out_sel, e);
                end
            end
        end
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s pulses: got %b want %b", tag, obs, exp);
        end
        if (exp != 8'h00) q.push_back(oh2id(exp));
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b0;
        rst_state = 1'b0;
        io.rsp_valid = 0; io.rst_tb_valid = 0;
        io.req_valid = 0; io.dma_valid = 0;
        io.rst_stall = 0; io.flush_stall = 0; io.req_stall = 0;
        io.recall_pending = 0; io.req_pending = 0;
        io.dma_read_pending = 0; io.dma_write_pending = 0;
        io.rst_to_resume_in_pipeline = 0;
        io.flush_to_resume_in_pipeline = 0;
        io.dma_read_to_resume_in_pipeline = 0;
        io.dma_write_to_resume_in_pipeline = 0;
        io.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        chk("rst_valid", 8'(io.out_valid), 8'h0);
        chk("rst_sel", 8'(io.out_sel), 8'h0);
        tick("rst_idle", 8'h00);

        // RSP beats REQ; REQ follows immediately since RSP sets no hold-off
        io.rsp_valid = 1; io.req_valid = 1;
        tick("rsp_first", 8'h01);
        io.rsp_valid = 0;
        tick("req_after_rsp", 8'h04);
        io.req_valid = 0;
        tick("req_hold", 8'h00);
        tick("idle1", 8'h00);

        // reset resume strobe, once
        io.rst_stall = 1;
        tick("res_rst", 8'h10);
        io.rst_to_resume_in_pipeline = 1;
        tick("res_rst_hold", 8'h00);
        tick("res_rst_flag", 8'h00);
        io.rst_stall = 0;
        io.rst_to_resume_in_pipeline = 0;
        tick("idle2", 8'h00);

        // flush resume > rst_tb > dma read resume
        io.flush_stall = 1; io.rst_tb_valid = 1;
        io.dma_read_pending = 1;
        tick("res_flush", 8'h20);
        io.flush_to_resume_in_pipeline = 1;
        tick("res_flush_hold", 8'h00);
        io.flush_stall = 0;
        io.flush_to_resume_in_pipeline = 0;
        tick("rst_tb", 8'h02);
        io.rst_tb_valid = 0;
        tick("rst_tb_hold", 8'h00);
        tick("res_dma_rd", 8'h40);
        io.dma_read_to_resume_in_pipeline = 1;
        tick("res_dma_rd_hold", 8'h00);
        tick("res_dma_rd_flag", 8'h00);
        io.dma_read_pending = 0;
        io.dma_read_to_resume_in_pipeline = 0;
        tick("idle3", 8'h00);

        // anti-starvation: REQ x4 then DMA x1, twice
        io.req_valid = 1; io.dma_valid = 1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                tick("starve_req", 8'h04);
                tick("starve_gap", 8'h00);
            end
            tick("starve_dma", 8'h08);
            tick("starve_gap", 8'h00);
        end

        // rst_state clears starve_cnt and drops the slot
        tick("pre_rs_req", 8'h04);
        tick("pre_rs_gap", 8'h00);
        tick("pre_rs_req", 8'h04);
        rst_state = 1;
        tick("rst_state", 8'h00);
        chk("rst_state_valid", 8'(io.out_valid), 8'h0);
        rst_state = 0;
        for (int i = 0; i < 4; i++) begin
            tick("rs_req", 8'h04);
            tick("rs_gap", 8'h00);
        end
        tick("rs_dma", 8'h08);
        io.req_valid = 0; io.dma_valid = 0;
        tick("rs_gap", 8'h00);
        tick("idle4", 8'h00);

        // decoder back-pressure keeps the slot stable
        io.out_ready = 0; io.req_valid = 1;
        tick("bp_req", 8'h04);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 8'(io.out_valid), 8'h1);
            chk("bp_sel", 8'(io.out_sel), 8'h2);
            tick("bp_stall", 8'h00);
        end
        io.out_ready = 1;
        tick("bp_drain", 8'h00);
        io.req_valid = 0;
        tick("idle5", 8'h00);

        // recall_pending admits only RSP
        io.recall_pending = 1; io.rsp_valid = 1;
        io.req_valid = 1; io.dma_valid = 1;
        tick("recall_rsp", 8'h01);
        io.rsp_valid = 0;
        tick("recall_blk", 8'h00);
        tick("recall_blk", 8'h00);
        io.recall_pending = 0;
        tick("recall_req", 8'h04);
        io.req_valid = 0; io.dma_valid = 0;
        tick("recall_gap", 8'h00);
        tick("idle6", 8'h00);

        // async reset with a full slot
        io.out_ready = 0; io.req_valid = 1;
        tick("ar_req", 8'h04);
        io.req_valid = 0;
        chk("ar_pre_valid", 8'(io.out_valid), 8'h1);
        rst = 0;
        #1;
        chk("ar_valid", 8'(io.out_valid), 8'h0);
        chk("ar_sel", 8'(io.out_sel), 8'h0);
        q.delete();
        #2 rst = 1;
        io.out_ready = 1;
        tick("ar_idle", 8'h00);
        io.req_valid = 1;
        tick("ar_req2", 8'h04);
        io.req_valid = 0;
        tick("ar_gap", 8'h00);
        tick("ar_idle2", 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
